// File: rtl/pz_sequencer.sv
// Serial pole/zero accumulator: walks a register file with a single adder,
// adding the first no_z entries and subtracting the next no_p entries.
module pz_sequencer #(
  parameter int unsigned REG_FILE_SIZE = 8,
  parameter int unsigned DATA_SIZE     = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_wr_en,
  input  logic [$clog2(REG_FILE_SIZE)-1:0]   i_wr_addr,
  input  logic [DATA_SIZE-1:0]               i_wr_data,
  input  logic                               i_start,
  input  logic [31:0]                        i_no_z,
  input  logic [31:0]                        i_no_p,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err,
  output logic [DATA_SIZE-1:0]               o_acc_pz,
  output logic [DATA_SIZE*REG_FILE_SIZE-1:0] o_flat_pz,
  output logic [31:0]                        o_lat_no_z,
  output logic [31:0]                        o_lat_no_p
);

  localparam int unsigned ADDR_W = $clog2(REG_FILE_SIZE);

  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e                r_state;
  logic [DATA_SIZE-1:0]  r_rf [REG_FILE_SIZE];
  logic [DATA_SIZE-1:0]  r_acc;
  logic [DATA_SIZE-1:0]  r_acc_pz;
  logic [ADDR_W-1:0]     r_idx;
  logic [ADDR_W-1:0]     r_last;
  logic [31:0]           r_lat_no_z;
  logic [31:0]           r_lat_no_p;
  logic                  r_done;
  logic                  r_err;

  logic [32:0]           w_n;
  logic                  w_wr_ok;
  logic                  w_is_zero;
  logic [DATA_SIZE-1:0]  w_entry;

  // 33-bit total so two full-range counts cannot wrap into a legal size
  assign w_n       = {1'b0, i_no_z} + {1'b0, i_no_p};
  assign w_wr_ok   = 32'(i_wr_addr) < REG_FILE_SIZE;
  assign w_is_zero = 32'(r_idx) < r_lat_no_z;
  assign w_entry   = r_rf[r_idx];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      for (int unsigned i = 0; i < REG_FILE_SIZE; i++) r_rf[i] <= '0;
      r_acc      <= '0;
      r_acc_pz   <= '0;
      r_idx      <= '0;
      r_last     <= '0;
      r_lat_no_z <= '0;
      r_lat_no_p <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_wr_en && w_wr_ok) r_rf[i_wr_addr] <= i_wr_data;
          if (i_start) begin
            if (w_n > 33'(REG_FILE_SIZE)) begin
              r_err <= 1'b1;
            end else begin
              r_lat_no_z <= i_no_z;
              r_lat_no_p <= i_no_p;
              r_idx      <= '0;
              r_acc      <= '0;
              r_last     <= ADDR_W'(w_n - 33'd1);
              r_state    <= (w_n == 33'd0) ? StFinish : StRun;
            end
          end
        end
        StRun: begin
          if (w_is_zero) r_acc <= r_acc + w_entry;
          else           r_acc <= r_acc - w_entry;
          r_idx <= r_idx + 1'b1;
          if (r_idx == r_last) r_state <= StFinish;
        end
        StFinish: begin
          r_acc_pz <= r_acc;
          r_done   <= 1'b1;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_flat_pz = '0;
    for (int unsigned i = 0; i < REG_FILE_SIZE; i++) begin
      o_flat_pz[DATA_SIZE*i +: DATA_SIZE] = r_rf[i];
    end
  end

  assign o_busy     = (r_state != StIdle);
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_acc_pz   = r_acc_pz;
  assign o_lat_no_z = r_lat_no_z;
  assign o_lat_no_p = r_lat_no_p;

endmodule

// File: doc/pz_sequencer.md
# pz_sequencer

Serial pole/zero accumulation controller for the filter-response path. Owns a REG_FILE_SIZE-entry pole/zero register file loaded through a write port. On `start` it walks the file one entry per cycle: it adds the first `no_z` entries, subtracts the next `no_p`, and returns the signed-wrap result with a one-cycle `done` pulse. It replaces the fully parallel combinational sum with a one-adder scheduled datapath. It also exports the register file and latched counts so a parallel accumulator can share the same storage.

## Interface
- `REG_FILE_SIZE`, default 8: number of pole/zero entries; must be ≥ 2.
- `DATA_SIZE`, default 16: width of each entry and of the result.
- `ADDR_W`, derived localparam, `$clog2(REG_FILE_SIZE)`: register-file address width.

- `clk`  in  1  — single clock; all logic on rising edge.
- `rst`  in  1  — reset; synchronous, active-high.
- `wr_en`  in  1  — write strobe for the register file.
- `wr_addr`  in  ADDR_W  — write index; values ≥ REG_FILE_SIZE are ignored.
- `wr_data`  in  DATA_SIZE  — entry value.
- `start`  in  1  — begin accumulation; sampled only in IDLE.
- `no_z`  in  32  — zero count; latched on accepted `start`.
- `no_p`  in  32  — pole count; latched on accepted `start`.
- `busy`  out  1  — high when state ≠ IDLE.
- `done`  out  1  — one-cycle pulse when `acc_pz` updates.
- `err`  out  1  — one-cycle pulse when `start` is rejected for a bad config.
- `acc_pz`  out  DATA_SIZE  — last result; holds its value between runs.
- `flat_pz`  out  DATA_SIZE*REG_FILE_SIZE  — register file contents; entry i at `[DATA_SIZE*i +: DATA_SIZE]`.
- `lat_no_z`  out  32  — zero count latched at the last accepted `start`.
- `lat_no_p`  out  32  — pole count latched at the last accepted `start`.

## Operation
- States: IDLE, RUN, FINISH.
- **Writes**
  - Committed only in IDLE.
  - `wr_en` while `busy` is dropped silently, so the file is frozen during a run.
- **IDLE, `start` = 1**
  - Let N = `no_z` + `no_p`, computed at 33 bits so no overflow.
  - If N > REG_FILE_SIZE: pulse `err`, stay IDLE; `acc_pz` and the latched counts are unchanged.
  - Otherwise: latch the counts, clear `idx` = 0 and `acc` = 0.
  - Next state is RUN if N > 0, or FINISH if N = 0.
- **RUN, one entry per cycle**
  - If `idx` < `lat_no_z`: `acc` += entry[idx]. Otherwise: `acc` −= entry[idx].
  - `idx`++; when `idx` = N−1 has been processed, go to FINISH.
- **FINISH**
  - `acc_pz` ← `acc`, `done` ← 1, then go to IDLE.
- **Arithmetic**
  - All sums are modulo 2^DATA_SIZE, two's-complement wrap.
  - No saturation.
  - The result is bit-identical to (Σ zeros − Σ poles) truncated to DATA_SIZE.
- **Ignored inputs**
  - `start` while `busy` is ignored; it is not queued.
- **Same-edge write and start in IDLE**
  - The write commits on that edge and the run reads the new value.
- **Reset** (at any time, including mid-run)
  - State → IDLE; the run is aborted with no `done`.
  - All register file entries = 0, `acc_pz` = 0.
  - `lat_no_z` = `lat_no_p` = 0.
  - `busy` = `done` = `err` = 0.

## Timing
- `start` accepted at edge k:
  - `busy` is high from after edge k.
  - `done` is high for exactly the cycle after edge k+N+1, with the new `acc_pz` valid in that same cycle.
  - `busy` drops in that same cycle.
- Minimum issue interval:
  - The next `start` can be accepted at edge k+N+2, i.e. back-to-back from the `done` cycle.
- Rejected `start` at edge k: `err` is high for the cycle after edge k; `busy` stays 0.
- Write at edge j: visible on `flat_pz` after edge j.
- `done` and `err` are never high in the same cycle.

## Test plan
- Reset, then read back: `acc_pz` = 0, `flat_pz` = 0, `busy` = `done` = `err` = 0.
- Write entries [3, 5, 2, 1]; start with `no_z` = 2, `no_p` = 2 → `acc_pz` = 0x0005 and `done` pulses 5 cycles after the start edge.
- Write [0x0001, 0x0000]; start with `no_z` = 0, `no_p` = 1 → `acc_pz` = 0xFFFF (wrap).
- Start with `no_z` = 0, `no_p` = 0 → `done` after 1 cycle, `acc_pz` = 0.
- Start with `no_z` = 5, `no_p` = 4 at REG_FILE_SIZE = 8 → `err` pulses once, `busy` stays 0, `acc_pz` unchanged.
- Mid-run disturbances:
  - Issue a write and a second `start` mid-run → both ignored, and the result matches the original file.
  - Assert `rst` mid-run → no `done`, all outputs return to 0.
